// File: rtl/acc_in_packer.sv
// acc_in_packer: packs a serial stream of signed 8-bit samples into
// 4-lane vectors, buffers them and offers them to the accelerator.
module acc_in_packer #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [7:0]             din,
    input  logic                   din_valid,
    input  logic                   din_last,
    output logic                   din_ready,
    output logic [7:0]             X1,
    output logic [7:0]             X2,
    output logic [7:0]             X3,
    output logic [7:0]             X4,
    output logic                   valid,
    input  logic                   ready,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_HOLD
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [HW-1:0]     hold_cnt;
    logic [HW-1:0]     hold_d;
    logic [1:0]        lane;
    logic [2:0][7:0]   asm_q;
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       push_word;

    assign din_ready = !arst && (fifo_count != CW'(DEPTH));
    assign accept    = din_valid && din_ready;
    assign push      = accept && ((lane == 2'd3) || din_last);

    // Lanes below the current one come from the assembly registers,
    // the current lane takes din, lanes above it are zero-filled.
    assign push_word[7:0]   = (lane == 2'd0) ? din : asm_q[0];
    assign push_word[15:8]  = (lane == 2'd1) ? din :
                              (lane > 2'd1)  ? asm_q[1] : 8'd0;
    assign push_word[23:16] = (lane == 2'd2) ? din :
                              (lane == 2'd3) ? asm_q[2] : 8'd0;
    assign push_word[31:24] = (lane == 2'd3) ? din : 8'd0;

    // Assembly: store accepted samples, restart the lane counter on push.
    always_ff @(posedge clk) begin
        if (arst) begin
            lane  <= 2'd0;
            asm_q <= '0;
        end else if (accept) begin
            if (push) begin
                lane <= 2'd0;
            end else begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0:    asm_q[0] <= din;
                    2'd1:    asm_q[1] <= din;
                    2'd2:    asm_q[2] <= din;
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage; push is already blocked while in reset or full.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Output FSM next state, pop request and valid.
    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        pop     = 1'b0;
        valid   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                valid = 1'b1;
                if (ready) begin
                    hold_d  = HW'(HOLD - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_cnt - HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output FSM registers; X lanes only change on an IDLE load.
    always_ff @(posedge clk) begin
        if (arst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            X1       <= 8'd0;
            X2       <= 8'd0;
            X3       <= 8'd0;
            X4       <= 8'd0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            if (pop) begin
                {X4, X3, X2, X1} <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_acc_in_packer.sv
// tb_acc_in_packer: directed vector table plus hand-written
// sequences for backpressure, push/pop overlap and mid-run reset.
module tb_acc_in_packer;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic [7:0] X1, X2, X3, X4;
    logic       valid;
    logic       ready;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       ev;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
        logic [7:0] e4;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl [15];

    acc_in_packer #(.DEPTH(4), .HOLD(2)) dut (
        .clk        (clk),
        .arst       (arst),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .X1         (X1),
        .X2         (X2),
        .X3         (X3),
        .X4         (X4),
        .valid      (valid),
        .ready      (ready),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d,
                         input logic l);
        din_valid = v;
        din       = d;
        din_last  = l;
    endtask

    task automatic check_all(input string name, input logic ev,
                             input logic [31:0] ex,
                             input logic [2:0] ec, input logic er);
        checks++;
        if (valid !== ev || {X4, X3, X2, X1} !== ex ||
            fifo_count !== ec || din_ready !== er) begin
            errors++;
            $display("FAIL %s: got valid=%0b X4..X1=%h cnt=%0d rdy=%0b, want valid=%0b X4..X1=%h cnt=%0d rdy=%0b",
                     name, valid, {X4, X3, X2, X1}, fifo_count,
                     din_ready, ev, ex, ec, er);
        end
    endtask

    task automatic wait_valid(input string name, input int max);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: valid=%0b after %0d cycles, want 1",
                     name, valid, max);
        end
    endtask

    task automatic do_reset();
        arst  = 1'b1;
        ready = 1'b0;
        drive(1'b1, 8'h37, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_all($sformatf("reset%0d", i), 1'b0, 32'h0, 3'd0, 1'b0);
        end
        arst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        step();
        check_all("post_reset", 1'b0, 32'h0, 3'd0, 1'b1);
    endtask

    function automatic logic [7:0] sv(input int n, input int i);
        return 8'(n * 37 + i * 11 + 3);
    endfunction

    function automatic logic [31:0] vw(input int n);
        return {sv(n, 3), sv(n, 2), sv(n, 1), sv(n, 0)};
    endfunction

    task automatic send(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, w[8*i +: 8], 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic all_acc;
        arst = 1'b1;
        ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        // v, d, l | ev, X1, X2, X3, X4, count
        tbl[0]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0};
        tbl[1]  = '{1'b1, 8'hFD, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0};
        tbl[2]  = '{1'b1, 8'h7F, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0};
        tbl[3]  = '{1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 8'hFD, 8'h7F, 8'h80, 3'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'hFD, 8'h7F, 8'h80, 3'd0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'hFD, 8'h7F, 8'h80, 3'd0};
        tbl[7]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 8'h05, 8'hFD, 8'h7F, 8'h80, 3'd0};
        tbl[8]  = '{1'b1, 8'h14, 1'b1, 1'b0, 8'h05, 8'hFD, 8'h7F, 8'h80, 3'd1};
        tbl[9]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h0A, 8'h14, 8'h00, 8'h00, 3'd0};
        tbl[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h0A, 8'h14, 8'h00, 8'h00, 3'd0};
        tbl[11] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h0A, 8'h14, 8'h00, 8'h00, 3'd0};
        tbl[12] = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h0A, 8'h14, 8'h00, 8'h00, 3'd1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 3'd0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 3'd0};

        // Basic pack and short frame, ready tied high
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].v, tbl[k].d, tbl[k].l);
            step();
            check_all($sformatf("tbl%0d", k), tbl[k].ev,
                      {tbl[k].e4, tbl[k].e3, tbl[k].e2, tbl[k].e1},
                      tbl[k].ec, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0);

        // Backpressure: 20 samples fill output register plus FIFO
        do_reset();
        all_acc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, sv(k / 4, k % 4), 1'b0);
            if (din_ready !== 1'b1) all_acc = 1'b0;
            step();
        end
        checks++;
        if (all_acc !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: got all_accepted=%0b want 1", all_acc);
        end
        drive(1'b0, 8'h00, 1'b0);
        check_all("bp_full", 1'b1, vw(0), 3'd4, 1'b0);
        drive(1'b1, 8'h63, 1'b0);
        step();
        check_all("bp_full_hold", 1'b1, vw(0), 3'd4, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) begin
                step();
                wait_valid($sformatf("bp_wait%0d", n), 12);
            end
            check_all($sformatf("bp_drain%0d", n), 1'b1, vw(n),
                      3'(4 - n), (n > 0) ? 1'b1 : 1'b0);
        end
        repeat (6) step();
        check_all("bp_empty", 1'b0, vw(4), 3'd0, 1'b1);

        // Push and IDLE pop on the same edge with one buffered vector
        do_reset();
        send(32'h04030201);
        check_all("pp_a_push", 1'b0, 32'h0, 3'd1, 1'b1);
        step();
        check_all("pp_a_load", 1'b1, 32'h04030201, 3'd0, 1'b1);
        send(32'h08070605);
        check_all("pp_b_push", 1'b1, 32'h04030201, 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(9 + i), 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_all("pp_xfer", 1'b0, 32'h04030201, 3'd1, 1'b1);
        step();
        step();
        check_all("pp_idle", 1'b0, 32'h04030201, 3'd1, 1'b1);
        drive(1'b1, 8'h0C, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        check_all("pp_same_edge", 1'b1, 32'h08070605, 3'd1, 1'b1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        wait_valid("pp_wait_c", 12);
        check_all("pp_c", 1'b1, 32'h0C0B0A09, 3'd0, 1'b1);

        // Reset while holding, with buffered vectors and partial lanes
        do_reset();
        send(32'h14131211);
        send(32'h24232221);
        send(32'h34333231);
        drive(1'b1, 8'h41, 1'b0);
        step();
        drive(1'b1, 8'h42, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_all("mr_hold", 1'b0, 32'h14131211, 3'd2, 1'b1);
        arst = 1'b1;
        drive(1'b1, 8'h55, 1'b0);
        step();
        check_all("mr_reset", 1'b0, 32'h0, 3'd0, 1'b0);
        arst = 1'b0;
        send(32'h64636261);
        check_all("mr_push", 1'b0, 32'h0, 3'd1, 1'b1);
        wait_valid("mr_wait", 12);
        check_all("mr_first", 1'b1, 32'h64636261, 3'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
